// File: rtl/convo_3x3.sv
// Strided 3x3 convolution over a 7x7 unsigned map (no padding), saturating to 8 bits.
// One output element is recomputed per clock in row-major order; the map sweeps continuously.
module convo_3x3 #(
    parameter int DATA_W = 8,
    parameter int IN_DIM = 7,
    parameter int K_DIM  = 3,
    parameter int STRIDE = 2,
    parameter int OUT_DIM = (IN_DIM - K_DIM) / STRIDE + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in     [IN_DIM][IN_DIM],
    input  logic [DATA_W-1:0] filter [K_DIM][K_DIM],
    output logic [DATA_W-1:0] out    [OUT_DIM][OUT_DIM]
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = 2 * DATA_W + 4;
    localparam int NPOS   = OUT_DIM * OUT_DIM;
    localparam int POS_W  = $clog2(NPOS + 1);
    localparam int OIDX_W = $clog2(OUT_DIM);
    localparam int IIDX_W = $clog2(IN_DIM);
    localparam int KIDX_W = $clog2(K_DIM);

    logic [POS_W-1:0]  pos_q;
    logic [POS_W-1:0]  pos_d;
    logic [DATA_W-1:0] out_q [OUT_DIM][OUT_DIM];
    logic [DATA_W-1:0] val_d;

    logic [OIDX_W-1:0] out_row_s;
    logic [OIDX_W-1:0] out_col_s;
    logic [IIDX_W-1:0] row_base_s;
    logic [IIDX_W-1:0] col_base_s;
    logic [IIDX_W-1:0] in_row_s;
    logic [IIDX_W-1:0] in_col_s;
    logic [PROD_W-1:0] prod_s;
    logic [ACC_W-1:0]  acc_s;

    // Anything wider than DATA_W clamps to all-ones.
    function automatic logic [DATA_W-1:0] sat_f(input logic [ACC_W-1:0] sum);
        logic [DATA_W-1:0] res;
        if (|sum[ACC_W-1:DATA_W]) begin
            res = {DATA_W{1'b1}};
        end else begin
            res = sum[DATA_W-1:0];
        end
        return res;
    endfunction

    // Decode the sweep position into output coordinates and the window origin.
    always_comb begin
        out_row_s = {OIDX_W{1'b0}};
        out_col_s = {OIDX_W{1'b0}};
        for (int p = 0; p < NPOS; p++) begin
            out_row_s = (pos_q == POS_W'(p)) ? OIDX_W'(p / OUT_DIM) : out_row_s;
            out_col_s = (pos_q == POS_W'(p)) ? OIDX_W'(p % OUT_DIM) : out_col_s;
        end
        row_base_s = IIDX_W'(STRIDE) * IIDX_W'(out_row_s);
        col_base_s = IIDX_W'(STRIDE) * IIDX_W'(out_col_s);
    end

    // Multiply-accumulate the window for the current position and saturate.
    always_comb begin
        acc_s    = {ACC_W{1'b0}};
        prod_s   = {PROD_W{1'b0}};
        in_row_s = {IIDX_W{1'b0}};
        in_col_s = {IIDX_W{1'b0}};
        for (int u = 0; u < K_DIM; u++) begin
            for (int v = 0; v < K_DIM; v++) begin
                in_row_s = row_base_s + IIDX_W'(u);
                in_col_s = col_base_s + IIDX_W'(v);
                prod_s   = PROD_W'(in[in_row_s][in_col_s]) *
                           PROD_W'(filter[KIDX_W'(u)][KIDX_W'(v)]);
                acc_s    = acc_s + ACC_W'(prod_s);
            end
        end
        val_d = sat_f(acc_s);
    end

    // Advance the position, wrapping after the last element (also recovers illegal codes).
    always_comb begin
        if (pos_q >= POS_W'(NPOS - 1)) begin
            pos_d = {POS_W{1'b0}};
        end else begin
            pos_d = pos_q + POS_W'(1);
        end
    end

    // Position counter and output map; only the addressed element updates.
    always_ff @(posedge clock) begin
        if (reset) begin
            pos_q <= {POS_W{1'b0}};
            for (int r = 0; r < OUT_DIM; r++) begin
                for (int c = 0; c < OUT_DIM; c++) begin
                    out_q[r][c] <= {DATA_W{1'b0}};
                end
            end
        end else begin
            pos_q                        <= pos_d;
            out_q[out_row_s][out_col_s]  <= val_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_convo_3x3.sv
// Self-checking bench for convo_3x3: reference model feeds a scoreboard queue of
// per-edge expected writes, plus full-map and directed constant checks.
module tb_convo_3x3;

    logic       clk;
    logic       rst;
    logic [7:0] in_s  [7][7];
    logic [7:0] flt_s [3][3];
    logic [7:0] out_s [3][3];

    int checks;
    int failures;
    int pos_m;
    logic [7:0] exp_map [3][3];
    int sb_q [$];

    convo_3x3 dut (
        .clock  (clk),
        .reset  (rst),
        .in     (in_s),
        .filter (flt_s),
        .out    (out_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_val(input int i, input int j);
        int sum;
        sum = 0;
        for (int u = 0; u < 3; u++) begin
            for (int v = 0; v < 3; v++) begin
                sum = sum + int'(in_s[2*i+u][2*j+v]) * int'(flt_s[u][v]);
            end
        end
        if (sum > 255) return 8'd255;
        return sum[7:0];
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_map(input string tag);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                check($sformatf("%s[%0d][%0d]", tag, r, c), int'(out_s[r][c]), int'(exp_map[r][c]));
            end
        end
    endtask

    task automatic set_in_all(input logic [7:0] val);
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++)
                in_s[r][c] = val;
    endtask

    task automatic set_flt_all(input logic [7:0] val);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                flt_s[r][c] = val;
    endtask

    task automatic set_flt_rows123();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                flt_s[r][c] = 8'(c + 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pos_m = 0;
        sb_q.delete();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                exp_map[r][c] = 8'd0;
        check_map("reset");
    endtask

    // One clock edge: predict the write, then pop and compare the written element.
    task automatic step();
        int i;
        int j;
        int entry;
        logic [7:0] e;
        i = pos_m / 3;
        j = pos_m % 3;
        e = model_val(i, j);
        sb_q.push_back(pos_m * 256 + int'(e));
        exp_map[i][j] = e;
        pos_m = (pos_m == 8) ? 0 : pos_m + 1;
        @(posedge clk);
        #1;
        entry = sb_q.pop_front();
        check($sformatf("write_pos%0d", entry / 256),
              int'(out_s[(entry / 256) / 3][(entry / 256) % 3]), entry % 256);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        pos_m    = 0;
        rst      = 1'b1;
        set_in_all(8'd1);
        set_flt_rows123();

        // Basic sweep: every element 18.
        do_reset();
        for (int k = 0; k < 9; k++) step();
        check_map("sweep18");
        check("sweep18_const", int'(out_s[2][2]), 18);

        // Update order: only the addressed element changes each edge.
        set_flt_all(8'd1);
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            step();
            check_map($sformatf("order_k%0d", k));
        end
        check("order_wrap_const", int'(out_s[0][0]), 9);

        // Index mapping with a single non-zero pixel.
        set_in_all(8'd0);
        in_s[2][2] = 8'd5;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                flt_s[r][c] = 8'(r * 3 + c + 1);
        do_reset();
        for (int k = 0; k < 9; k++) step();
        check_map("index");
        check("index00", int'(out_s[0][0]), 45);
        check("index01", int'(out_s[0][1]), 35);
        check("index10", int'(out_s[1][0]), 15);
        check("index11", int'(out_s[1][1]), 5);
        check("index22", int'(out_s[2][2]), 0);

        // Saturation, then recovery on the following sweep.
        set_in_all(8'd255);
        set_flt_all(8'd255);
        do_reset();
        for (int k = 0; k < 9; k++) step();
        check_map("sat");
        check("sat_const", int'(out_s[1][2]), 255);
        set_in_all(8'd1);
        set_flt_all(8'd1);
        for (int k = 0; k < 9; k++) step();
        check_map("unsat");
        check("unsat_const", int'(out_s[2][1]), 9);

        // Mid-sweep reset.
        set_flt_rows123();
        do_reset();
        for (int k = 0; k < 4; k++) step();
        check("mid_pre_const", int'(out_s[1][0]), 18);
        do_reset();
        step();
        check("mid_first_const", int'(out_s[0][0]), 18);
        check("mid_other_const", int'(out_s[0][1]), 0);
        for (int k = 0; k < 8; k++) step();
        check_map("mid_full");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
